// File: rtl/mdio_phy_responder_if.sv
// MDIO pad and status bundle between an MDIO master (or bench) and the PHY-side responder.
// mdio_i is the resolved pad value; mdio_o/mdio_t are the responder's pad driver controls.
interface mdio_phy_responder_if;
   logic        mdc;
   logic        mdio_i;
   logic        mdio_o;
   logic        mdio_t;
   logic        wr_valid;
   logic [4:0]  wr_addr;
   logic [15:0] wr_data;
   logic        rd_valid;
   logic [7:0]  frame_err_cnt;
   logic        busy;

   modport master (
      output mdc, mdio_i,
      input  mdio_o, mdio_t, wr_valid, wr_addr, wr_data, rd_valid, frame_err_cnt, busy
   );

   modport slave (
      input  mdc, mdio_i,
      output mdio_o, mdio_t, wr_valid, wr_addr, wr_data, rd_valid, frame_err_cnt, busy
   );
endinterface

// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO PHY responder: oversamples MDC/MDIO in the clk domain, decodes frames and
// serves a 32 x 16-bit register file (reg2/reg3 hold the read-only PHY ID).
module mdio_phy_responder #(
   parameter logic [4:0]  PHY_ADDR     = 5'b00100,
   parameter logic [31:0] PHY_ID       = 32'h0141_0DD1,
   parameter int unsigned PREAMBLE_LEN = 32
) (
   input logic                  clk,
   input logic                  rst,
   mdio_phy_responder_if.slave  bus
);

   localparam logic [2:0] ST_PRE   = 3'd0;
   localparam logic [2:0] ST_ST    = 3'd1;
   localparam logic [2:0] ST_OP    = 3'd2;
   localparam logic [2:0] ST_PHYAD = 3'd3;
   localparam logic [2:0] ST_REGAD = 3'd4;
   localparam logic [2:0] ST_TA    = 3'd5;
   localparam logic [2:0] ST_WDATA = 3'd6;
   localparam logic [2:0] ST_RDATA = 3'd7;

   logic [2:0]  mdc_sync;
   logic [1:0]  mdio_sync;
   logic        rise, fall, sample;

   logic [2:0]  state_q, state_d;
   logic [5:0]  pre_cnt_q, pre_cnt_d;
   logic [4:0]  bit_cnt_q, bit_cnt_d;
   logic        op_hi_q, op_hi_d;
   logic        is_rd_q, is_rd_d;
   logic        match_q, match_d;
   logic [3:0]  phyad_q, phyad_d;
   logic [4:0]  regad_q, regad_d;
   logic [14:0] shift_q, shift_d;
   logic [15:0] rd_data_q, rd_data_d;
   logic        mdio_t_q, mdio_t_d;
   logic        mdio_o_q, mdio_o_d;
   logic        wr_valid_q, wr_valid_d;
   logic [4:0]  wr_addr_q, wr_addr_d;
   logic [15:0] wr_data_q, wr_data_d;
   logic        rd_valid_q, rd_valid_d;
   logic [7:0]  err_q, err_d;
   logic        busy_q, busy_d;
   logic        commit, frame_err, soft_clr_q;
   logic [15:0] reg_rd;
   logic [15:0] regs [32];

   assign rise   = mdc_sync[1] & ~mdc_sync[2];
   assign fall   = ~mdc_sync[1] & mdc_sync[2];
   assign sample = mdio_sync[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mdc_sync  <= '0;
         mdio_sync <= 2'b11;
      end else begin
         mdc_sync  <= {mdc_sync[1:0], bus.mdc};
         mdio_sync <= {mdio_sync[0], bus.mdio_i};
      end
   end

   always_comb begin
      case (regad_q)
         5'd2:    reg_rd = PHY_ID[31:16];
         5'd3:    reg_rd = PHY_ID[15:0];
         default: reg_rd = regs[regad_q];
      endcase
   end

   always_comb begin
      state_d    = state_q;
      pre_cnt_d  = pre_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      op_hi_d    = op_hi_q;
      is_rd_d    = is_rd_q;
      match_d    = match_q;
      phyad_d    = phyad_q;
      regad_d    = regad_q;
      shift_d    = shift_q;
      rd_data_d  = rd_data_q;
      mdio_t_d   = mdio_t_q;
      mdio_o_d   = mdio_o_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      err_d      = err_q;
      busy_d     = busy_q;
      wr_valid_d = 1'b0;
      rd_valid_d = 1'b0;
      commit     = 1'b0;
      frame_err  = 1'b0;

      case (state_q)
         ST_PRE: if (rise) begin
            if (sample) begin
               pre_cnt_d = (pre_cnt_q == 6'd63) ? pre_cnt_q : pre_cnt_q + 6'd1;
            end else if ({26'd0, pre_cnt_q} >= PREAMBLE_LEN) begin
               state_d   = ST_ST;
               busy_d    = 1'b1;
               pre_cnt_d = '0;
            end else begin
               pre_cnt_d = '0;
            end
         end
         ST_ST: if (rise) begin
            if (sample) begin
               state_d   = ST_OP;
               bit_cnt_d = '0;
            end else begin
               frame_err = 1'b1;
            end
         end
         ST_OP: if (rise) begin
            op_hi_d   = sample;
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd1) begin
               bit_cnt_d = '0;
               state_d   = ST_PHYAD;
               case ({op_hi_q, sample})
                  2'b10:   is_rd_d = 1'b1;
                  2'b01:   is_rd_d = 1'b0;
                  default: frame_err = 1'b1;
               endcase
            end
         end
         ST_PHYAD: if (rise) begin
            phyad_d   = {phyad_q[2:0], sample};
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd4) begin
               match_d   = ({phyad_q, sample} == PHY_ADDR);
               bit_cnt_d = '0;
               state_d   = ST_REGAD;
            end
         end
         ST_REGAD: if (rise) begin
            regad_d   = {regad_q[3:0], sample};
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd4) begin
               bit_cnt_d = '0;
               state_d   = ST_TA;
            end
         end
         ST_TA: if (rise) begin
            if (is_rd_q) begin
               // Snapshot read data at TA bit0 so a concurrent write cannot tear it.
               rd_data_d = reg_rd;
               bit_cnt_d = '0;
               state_d   = ST_RDATA;
            end else if (bit_cnt_q == 5'd0) begin
               if (sample) bit_cnt_d = 5'd1;
               else        frame_err = 1'b1;
            end else if (!sample) begin
               bit_cnt_d = '0;
               state_d   = ST_WDATA;
            end else begin
               frame_err = 1'b1;
            end
         end
         ST_WDATA: if (rise) begin
            shift_d   = {shift_q[13:0], sample};
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd15) begin
               if (match_q && regad_q != 5'd2 && regad_q != 5'd3) begin
                  commit     = 1'b1;
                  wr_valid_d = 1'b1;
                  wr_addr_d  = regad_q;
                  wr_data_d  = {shift_q, sample};
               end
               bit_cnt_d = '0;
               state_d   = ST_PRE;
               busy_d    = 1'b0;
            end
         end
         ST_RDATA: if (fall) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd0) begin
               if (match_q) begin
                  mdio_t_d = 1'b0;
                  mdio_o_d = 1'b0;
               end
            end else if (bit_cnt_q <= 5'd16) begin
               if (match_q) mdio_o_d = rd_data_q[15];
               rd_data_d = {rd_data_q[14:0], 1'b0};
            end else begin
               mdio_t_d   = 1'b1;
               mdio_o_d   = 1'b1;
               rd_valid_d = match_q;
               bit_cnt_d  = '0;
               state_d    = ST_PRE;
               busy_d     = 1'b0;
            end
         end
         default: state_d = ST_PRE;
      endcase

      if (frame_err) begin
         err_d     = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
         mdio_t_d  = 1'b1;
         mdio_o_d  = 1'b1;
         state_d   = ST_PRE;
         pre_cnt_d = '0;
         bit_cnt_d = '0;
         busy_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_PRE;
         pre_cnt_q  <= '0;
         bit_cnt_q  <= '0;
         op_hi_q    <= 1'b0;
         is_rd_q    <= 1'b0;
         match_q    <= 1'b0;
         phyad_q    <= '0;
         regad_q    <= '0;
         shift_q    <= '0;
         rd_data_q  <= '0;
         mdio_t_q   <= 1'b1;
         mdio_o_q   <= 1'b1;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         rd_valid_q <= 1'b0;
         err_q      <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pre_cnt_q  <= pre_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         op_hi_q    <= op_hi_d;
         is_rd_q    <= is_rd_d;
         match_q    <= match_d;
         phyad_q    <= phyad_d;
         regad_q    <= regad_d;
         shift_q    <= shift_d;
         rd_data_q  <= rd_data_d;
         mdio_t_q   <= mdio_t_d;
         mdio_o_q   <= mdio_o_d;
         wr_valid_q <= wr_valid_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         rd_valid_q <= rd_valid_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
      end
   end

   // Soft-reset bit reg0[15] is visible on the commit pulse, then clears itself.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         soft_clr_q <= 1'b0;
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else begin
         soft_clr_q <= commit && (regad_q == 5'd0) && shift_q[14];
         if (commit) regs[regad_q] <= {shift_q, sample};
         if (soft_clr_q) regs[0][15] <= 1'b0;
      end
   end

   assign bus.mdio_o        = mdio_o_q;
   assign bus.mdio_t        = mdio_t_q;
   assign bus.wr_valid      = wr_valid_q;
   assign bus.wr_addr       = wr_addr_q;
   assign bus.wr_data       = wr_data_q;
   assign bus.rd_valid      = rd_valid_q;
   assign bus.frame_err_cnt = err_q;
   assign bus.busy          = busy_q;

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Directed bench for mdio_phy_responder: bit-banged Clause-22 frames with hand-computed results.
module tb_mdio_phy_responder;
   localparam int H = 8;  // clk cycles per MDC half period

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic m_drv = 1'b1;
   int   compared = 0;
   int   failed = 0;
   int   wr_cnt = 0;
   int   rd_cnt = 0;
   int   tlow;
   logic busy_seen;
   logic [4:0]  last_addr = '0;
   logic [15:0] last_data = '0;
   logic [15:0] rdata;
   logic        ta0;

   mdio_phy_responder_if bus ();

   // Pad model: the responder wins the wire while driving, else the master's value.
   assign bus.mdio_i = bus.mdio_t ? m_drv : bus.mdio_o;

   mdio_phy_responder dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #4 clk = ~clk;

   always @(posedge clk) begin
      if (bus.wr_valid) begin
         wr_cnt    <= wr_cnt + 1;
         last_addr <= bus.wr_addr;
         last_data <= bus.wr_data;
      end
      if (bus.rd_valid) rd_cnt <= rd_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      assert (got === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clock_bit(input logic b, output logic s);
      m_drv = b;
      repeat (H) @(negedge clk);
      s = bus.mdio_i;
      if (!bus.mdio_t) tlow++;
      busy_seen |= bus.busy;
      bus.mdc = 1'b1;
      repeat (H) @(negedge clk);
      bus.mdc = 1'b0;
   endtask

   task automatic send_bits(input logic [31:0] v, input int n);
      logic s;
      for (int i = n - 1; i >= 0; i--) clock_bit(v[i], s);
   endtask

   task automatic header(input int npre, input logic [1:0] op, input logic [4:0] pa,
                         input logic [4:0] ra);
      tlow = 0;
      busy_seen = 1'b0;
      for (int i = 0; i < npre; i++) send_bits(32'd1, 1);
      send_bits(32'b01, 2);
      send_bits({30'd0, op}, 2);
      send_bits({27'd0, pa}, 5);
      send_bits({27'd0, ra}, 5);
   endtask

   task automatic mdio_write(input int npre, input logic [1:0] op, input logic [4:0] ra,
                             input logic [1:0] ta, input logic [15:0] d);
      header(npre, op, 5'b00100, ra);
      send_bits({30'd0, ta}, 2);
      send_bits({16'd0, d}, 16);
      m_drv = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   // rst_at > 0 asserts reset just before the rising edge of sample slot rst_at.
   task automatic mdio_read(input int npre, input logic [4:0] pa, input logic [4:0] ra,
                            input int rst_at, output logic [15:0] d, output logic ta_bit);
      logic s;
      d = 'x;
      ta_bit = 1'bx;
      header(npre, 2'b10, pa, ra);
      clock_bit(1'b1, s);
      for (int k = 1; k <= 17; k++) begin
         if (k == rst_at) begin
            m_drv = 1'b1;
            repeat (H) @(negedge clk);
            chk("drive_before_rst", {31'd0, bus.mdio_t}, 32'd0);
            rst = 1'b1;
            #1;
            chk("mdio_t_on_rst", {31'd0, bus.mdio_t}, 32'd1);
            chk("err_cnt_on_rst", {24'd0, bus.frame_err_cnt}, 32'd0);
            @(negedge clk);
            rst = 1'b0;
            repeat (4) @(negedge clk);
            return;
         end
         clock_bit(1'b1, s);
         if (k == 1) ta_bit = s;
         else d[17-k] = s;
      end
      repeat (6) @(negedge clk);
   endtask

   initial begin
      bus.mdc = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_mdio_t", {31'd0, bus.mdio_t}, 32'd1);
      chk("rst_mdio_o", {31'd0, bus.mdio_o}, 32'd1);
      chk("rst_wr_valid", {31'd0, bus.wr_valid}, 32'd0);
      chk("rst_wr_addr", {27'd0, bus.wr_addr}, 32'd0);
      chk("rst_wr_data", {16'd0, bus.wr_data}, 32'd0);
      chk("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
      chk("rst_err_cnt", {24'd0, bus.frame_err_cnt}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      mdio_write(32, 2'b01, 5'd4, 2'b10, 16'hA5C3);
      chk("wr4_count", wr_cnt, 32'd1);
      chk("wr4_addr", {27'd0, last_addr}, 32'd4);
      chk("wr4_data", {16'd0, last_data}, 32'hA5C3);
      chk("wr4_busy_seen", {31'd0, busy_seen}, 32'd1);
      chk("wr4_busy_after", {31'd0, bus.busy}, 32'd0);

      mdio_read(32, 5'b00100, 5'd4, 0, rdata, ta0);
      chk("rd4_data", {16'd0, rdata}, 32'hA5C3);
      chk("rd4_ta", {31'd0, ta0}, 32'd0);
      chk("rd4_drive_periods", tlow, 32'd17);
      chk("rd4_rd_valid", rd_cnt, 32'd1);
      chk("rd4_released", {31'd0, bus.mdio_t}, 32'd1);

      mdio_read(32, 5'b00100, 5'd2, 0, rdata, ta0);
      chk("rd2_id", {16'd0, rdata}, 32'h0141);
      mdio_read(32, 5'b00100, 5'd3, 0, rdata, ta0);
      chk("rd3_id", {16'd0, rdata}, 32'h0DD1);

      mdio_write(32, 2'b01, 5'd2, 2'b10, 16'hFFFF);
      chk("wr2_no_valid", wr_cnt, 32'd1);
      chk("wr2_no_err", {24'd0, bus.frame_err_cnt}, 32'd0);
      mdio_read(32, 5'b00100, 5'd2, 0, rdata, ta0);
      chk("rd2_after_wr", {16'd0, rdata}, 32'h0141);
      chk("rd_count_4", rd_cnt, 32'd4);

      mdio_read(32, 5'b00101, 5'd4, 0, rdata, ta0);
      chk("mismatch_no_drive", tlow, 32'd0);
      chk("mismatch_no_rd_valid", rd_cnt, 32'd4);
      chk("mismatch_no_err", {24'd0, bus.frame_err_cnt}, 32'd0);

      mdio_read(31, 5'b00100, 5'd4, 0, rdata, ta0);
      chk("pre31_no_drive", tlow, 32'd0);
      chk("pre31_no_rd_valid", rd_cnt, 32'd4);
      chk("pre31_no_err", {24'd0, bus.frame_err_cnt}, 32'd0);

      mdio_write(32, 2'b11, 5'd5, 2'b10, 16'h1234);
      chk("op11_err", {24'd0, bus.frame_err_cnt}, 32'd1);
      mdio_write(32, 2'b01, 5'd5, 2'b11, 16'h5A5A);
      chk("ta11_err", {24'd0, bus.frame_err_cnt}, 32'd2);
      chk("ta11_no_write", wr_cnt, 32'd1);

      mdio_read(32, 5'b00100, 5'd4, 0, rdata, ta0);
      chk("rd4_after_errs", {16'd0, rdata}, 32'hA5C3);
      mdio_read(32, 5'b00100, 5'd5, 0, rdata, ta0);
      chk("rd5_unwritten", {16'd0, rdata}, 32'h0000);
      chk("rd_count_6", rd_cnt, 32'd6);

      mdio_write(32, 2'b01, 5'd0, 2'b10, 16'h8123);
      chk("wr0_count", wr_cnt, 32'd2);
      chk("wr0_addr", {27'd0, last_addr}, 32'd0);
      chk("wr0_data_shows_bit15", {16'd0, last_data}, 32'h8123);
      mdio_read(32, 5'b00100, 5'd0, 0, rdata, ta0);
      chk("rd0_self_cleared", {16'd0, rdata}, 32'h0123);

      mdio_read(32, 5'b00100, 5'd4, 10, rdata, ta0);
      mdio_read(32, 5'b00100, 5'd4, 0, rdata, ta0);
      chk("rd4_after_rst", {16'd0, rdata}, 32'h0000);
      chk("rd4_after_rst_ta", {31'd0, ta0}, 32'd0);
      chk("err_after_rst", {24'd0, bus.frame_err_cnt}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end
endmodule

// File: doc/mdio_phy_responder.md
Name: mdio_phy_responder

Overview:
- PHY-side MDIO management responder: the slave end of the Clause-22 frames our MDIO master issues over MDC/MDIO.
- Oversamples MDC and MDIO in the system clock domain and decodes the frame.
- Holds a 32 x 16-bit PHY register file; serves reads by driving MDIO and commits writes.
- Used as a PHY model in benches and as a loopback target on the board when no PHY is fitted.

Parameters:
- PHY_ADDR, 5'b00100: PHY address this block answers to.
- PHY_ID, 32'h0141_0DD1: read-only value of reg2 (bits [31:16]) and reg3 (bits [15:0]).
- PREAMBLE_LEN, 32: consecutive 1 bits required before ST; range 1..63.

Ports:
- clk  in  1  system clock (125 MHz).
- rst  in  1  reset; asynchronous, active-high.
- mdc  in  1  MDIO clock from master; asynchronous to clk.
- mdio_i  in  1  MDIO pad input.
- mdio_o  out  1  MDIO pad output value.
- mdio_t  out  1  tristate enable; 1 = released/input, 0 = driving mdio_o.
- wr_valid  out  1  one-clk pulse when a write commits.
- wr_addr  out  5  register address of the committed write.
- wr_data  out  16  data of the committed write.
- rd_valid  out  1  one-clk pulse when a read frame for this PHY completes.
- frame_err_cnt  out  8  count of malformed frames; saturates at 255.
- busy  out  1  high from ST detection until return to PRE.

Behaviour:
- Reset values:
  - mdio_t=1, mdio_o=1; wr_valid=0, wr_addr=0, wr_data=0; rd_valid=0; frame_err_cnt=0; busy=0; state=PRE, preamble count=0.
  - Register file all 0, except reg2/reg3 which read PHY_ID.
- Synchronisation and edge detection:
  - mdc and mdio_i each pass through a 2-flop synchroniser.
  - Rising edge = synced mdc high and previous sample low; falling edge is the inverse.
  - Edge detect lags the pin by 3 clk.
- Sampling: MDIO is sampled only on detected MDC rising edges. Outputs change only on detected MDC falling edges.
- States: PRE -> ST -> OP -> PHYAD -> REGAD -> TA -> (WDATA | RDATA) -> PRE.
- PRE:
  - A sampled 1 increments the preamble count, saturating at 63.
  - A sampled 0 with count >= PREAMBLE_LEN is taken as ST bit0: go to ST, busy=1.
  - A sampled 0 with count < PREAMBLE_LEN clears the count; this is not an error.
- ST: expects a 1; otherwise error.
- OP: 2 bits, MSB first. 10 = read, 01 = write; any other value is an error.
- PHYAD: 5 bits, MSB first, then REGAD: 5 bits, MSB first.
- Match flag: set when PHYAD == PHY_ADDR. A mismatched frame is tracked to its end but never drives MDIO, never writes, and never pulses rd_valid or wr_valid.
- TA, read with match:
  - mdio_t stays 1 during TA bit0.
  - On the falling edge after the TA bit0 rising sample: mdio_t=0, mdio_o=0.
  - On each of the next 16 falling edges, drive data bit 15 down to 0.
  - On the 17th falling edge: mdio_t=1, rd_valid pulses, go to PRE.
- TA, write:
  - The two sampled TA bits must be 1,0; otherwise error.
  - WDATA: 16 bits, MSB first.
  - On the 16th rising sample, if matched and REGAD is not 2 or 3: update the register file; wr_valid=1 with wr_addr/wr_data on the same cycle; go to PRE.
- Writes to reg2/reg3 are ignored silently: no wr_valid, no error.
- Reg0 bit15 (soft reset) self-clears one clk after commit. The wr_valid/wr_data pulse still shows bit15=1.
- Error handling: frame_err_cnt += 1 (saturating), mdio_t=1, go to PRE with preamble count=0.
- Preamble after a frame: the count restarts at 0 after every frame; preamble suppression is not supported.
- Reset mid-frame: asynchronous return to reset values, and MDIO is released within the same cycle. Register contents are also reset.
- MDC constraint: MDC high and low each >= 4 clk; at 2.5 MHz MDC this is 25 clk each.

Test Plan:
- Write path: 32x1 preamble, ST=01, OP=01, PHYAD=00100, REGAD=4, TA=10, data 16'hA5C3 -> one wr_valid pulse, wr_addr=4, wr_data=16'hA5C3; reg4=16'hA5C3.
- Read-back: read of REGAD=4 after the write -> mdio_t=0 for exactly 17 MDC periods (TA bit1 plus 16 data); the master samples 0 then 1010_0101_1100_0011; rd_valid pulses once.
- ID regs: read reg2 and reg3 -> 16'h0141 and 16'h0DD1. Then write 16'hFFFF to reg2 -> no wr_valid; reg2 read still 16'h0141.
- PHY address mismatch: PHYAD=00101 read -> mdio_t stays 1 throughout; rd_valid=0; frame_err_cnt unchanged.
- Malformed frames:
  - 31-bit preamble then 01 -> no response, no error.
  - OP=11 -> frame_err_cnt=1.
  - Write with TA=11 -> frame_err_cnt=2, no write.
  - A following valid read succeeds.
- Reset mid-read: assert rst during data bit 7 of a read -> mdio_t=1 in the same cycle and frame_err_cnt=0. The next full read of reg4 returns 0.
